score_display: RTL

Parametrised score-to-seven-segment display engine for the DE10-Lite HEX bank. It replaces the per-digit combinational HEX wiring in the game top level. It accepts a binary score or debug value through a load/busy/done handshake and converts it to BCD with a sequential double-dabble engine, or passes it through as hex. It then commits all digits to registered, active-low segment outputs in a single cycle, so the display never shows a partial result.

---
 rtl/score_display_pkg.sv | 54 +++++
 rtl/score_display_seg7_glyph.sv | 11 +
 rtl/score_display.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared types and active-low seven-segment glyph constants for score_display.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  // Segment order within a glyph is {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  function automatic logic [6:0] glyph7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/score_display_seg7_glyph.sv
// seg7_glyph: combinational nibble to active-low {g,f,e,d,c,b,a} encoder.
module seg7_glyph
  import score_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = glyph7(i_nibble);

endmodule

// File: rtl/score_display.sv
// score_display: binary score to registered seven-segment digits via double dabble.
// Optional build macro SCORE_DISPLAY_LZB_EN enables leading-zero blanking in decimal mode.
module score_display
  import score_display_pkg::*;
#(
  parameter int VALUE_W    = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    load,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    hex_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] seg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [BCD_W-1:0]          r_bcd;
  logic [VALUE_W-1:0]        r_bin;
  logic                      r_hexMode;
  logic                      r_ovf;
  logic [8*NUM_DIGITS-1:0]   r_seg;
  logic                      r_overflow;
  logic                      r_done;

  logic [BCD_W-1:0]          w_adj;
  logic [BCD_W-1:0]          w_valExt;
  logic                      w_hexOvf;
  logic                      w_ovfNow;
  logic [BCD_W-1:0]          w_nib;
  logic [7*NUM_DIGITS-1:0]   w_glyph;
  logic [NUM_DIGITS-1:0]     w_blank;
  logic [8*NUM_DIGITS-1:0]   w_segNext;

  // Hex view of the captured value: zero-extend, or flag bits beyond the display.
  if (VALUE_W > BCD_W) begin : g_wide
    assign w_valExt = r_bin[BCD_W-1:0];
    assign w_hexOvf = |r_bin[VALUE_W-1:BCD_W];
  end else begin : g_narrow
    assign w_valExt = BCD_W'(r_bin);
    assign w_hexOvf = 1'b0;
  end

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end else begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
    end
  end

  assign w_nib    = r_hexMode ? w_valExt : r_bcd;
  assign w_ovfNow = r_hexMode ? w_hexOvf : r_ovf;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_glyph u_glyph (
      .i_nibble (w_nib[4*g +: 4]),
      .o_seg    (w_glyph[7*g +: 7])
    );
  end

`ifdef SCORE_DISPLAY_LZB_EN
  // A digit is blanked only if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic v_allZero;
    v_allZero = 1'b1;
    w_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      v_allZero  = v_allZero && (r_bcd[4*i +: 4] == 4'd0);
      w_blank[i] = v_allZero && !r_hexMode;
    end
  end
`else
  assign w_blank = '0;
`endif

  always_comb begin
    w_segNext = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_ovfNow) begin
        w_segNext[8*i +: 8] = {1'b1, SEG_DASH};
      end else if (w_blank[i]) begin
        w_segNext[8*i +: 8] = {1'b1, SEG_BLANK};
      end else begin
        w_segNext[8*i +: 8] = {1'b1, w_glyph[7*i +: 7]};
      end
    end
  end

  // The top BCD bit after the add-3 step is what gets shifted out; any 1 there is overflow.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_bin      <= '0;
      r_hexMode  <= 1'b0;
      r_ovf      <= 1'b0;
      r_seg      <= {NUM_DIGITS{8'hFF}};
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin     <= value;
            r_hexMode <= hex_mode;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_state   <= hex_mode ? COMMIT : CONV;
          end
        end
        CONV: begin
          r_bcd <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
          r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
          if (w_adj[BCD_W-1]) begin
            r_ovf <= 1'b1;
          end
          if (r_cnt == CNT_W'(VALUE_W - 1)) begin
            r_state <= COMMIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          r_seg      <= w_segNext;
          r_overflow <= w_ovfNow;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign seg      = r_seg;

endmodule
